// File: rtl/piso_transmitter.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word on start and
// shifts it out LSB first, one bit per clock, followed by a one-cycle done pulse.
// All outputs come straight from flops, so no input reaches an output in the
// same cycle.
module piso_transmitter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             done
);

    // Counter holds the index of the bit currently on sout (0..WIDTH-1).
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [CntW-1:0]  cnt_inc;

    // Only used where cnt_q < LastIdx, so the increment never wraps.
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so they can be registered.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        sout_d  = sout_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = done_q;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                sout_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b0;
                if (start) begin
                    state_d = StShift;
                    shreg_d = din;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    // Bit 0 goes out in the cycle right after acceptance.
                    sout_d  = din[0];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end

            StShift: begin
                ready_d = 1'b0;
                if (cnt_q == LastIdx) begin
                    state_d = StDone;
                    shreg_d = '0;
                    sout_d  = 1'b0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                    // shreg_q[0] is already on sout; bit 1 is the next one out.
                    shreg_d = shreg_q >> 1;
                    sout_d  = shreg_q[1];
                    valid_d = 1'b1;
                    last_d  = (cnt_inc == LastIdx);
                end
            end

            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
                ready_d = 1'b1;
                sout_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                shreg_d = '0;
                cnt_d   = '0;
                ready_d = 1'b1;
                sout_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign ready      = ready_q;
    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign last       = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_transmitter.sv
// Bench for piso_transmitter: an 8-bit and a 2-bit instance share stimulus.
// A transaction model queues the expected bit stream per accepted word; a
// negedge monitor pops and compares whatever the DUTs present.
module tb_piso_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;

    logic r8, s8, v8, l8, d8;
    logic r2, s2, v2, l2, d2;

    piso_transmitter #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .ready      (r8),
        .sout       (s8),
        .sout_valid (v8),
        .last       (l8),
        .done       (d8)
    );

    piso_transmitter #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din[1:0]),
        .ready      (r2),
        .sout       (s2),
        .sout_valid (v2),
        .last       (l2),
        .done       (d2)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic is_done;
        logic b;
        logic lst;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    int   free8 = 0;   // first edge at which dut8 may accept again
    int   free2 = 0;
    int   edge_n = 0;
    int   total = 0;
    int   bad = 0;
    bit   cont = 1'b0;
    int   last_done8 = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_n);
        end
    endfunction

    // Reference model: a word is accepted when start is seen at an edge no
    // earlier than WIDTH+2 edges after the previous acceptance.
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            q8.delete();
            q2.delete();
            free8 = 0;
            free2 = 0;
        end else if (start) begin
            if (edge_n >= free8) begin
                for (int k = 0; k < 8; k++) q8.push_back('{1'b0, din[k], 1'(k == 7)});
                q8.push_back('{1'b1, 1'b0, 1'b0});
                free8 = edge_n + 10;
            end
            if (edge_n >= free2) begin
                for (int k = 0; k < 2; k++) q2.push_back('{1'b0, din[k], 1'(k == 1)});
                q2.push_back('{1'b1, 1'b0, 1'b0});
                free2 = edge_n + 4;
            end
        end
    end

    task automatic observe(input int id, input logic rdy, input logic s, input logic v,
                           input logic l, input logic d);
        exp_t e;
        int   fr;
        bit   have;
        fr   = (id == 0) ? free8 : free2;
        have = (id == 0) ? (q8.size() != 0) : (q2.size() != 0);
        check($sformatf("ready w%0d", id), rdy, 32'(fr <= edge_n + 1));
        check($sformatf("activity w%0d", id), v | d, 32'(have));
        if (have && (v | d)) begin
            e = (id == 0) ? q8.pop_front() : q2.pop_front();
            check($sformatf("done w%0d", id), d, e.is_done);
            check($sformatf("valid w%0d", id), v, !e.is_done);
            check($sformatf("sout w%0d", id), s, e.b);
            check($sformatf("last w%0d", id), l, e.lst);
        end else if (!(v | d)) begin
            check($sformatf("idle sout/last w%0d", id), {s, l}, 0);
        end
    endtask

    // Monitor samples away from the active edge.
    always @(negedge clk) begin
        observe(0, r8, s8, v8, l8, d8);
        observe(1, r2, s2, v2, l2, d2);
        if (d8) begin
            if (cont && last_done8 != 0) check("done period", edge_n - last_done8, 10);
            last_done8 = edge_n;
        end
    end

    // Asynchronous reset pulse between clock edges; outputs must settle at once.
    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1;
        check("async rst w8", {r8, s8, v8, l8, d8}, 5'b10000);
        check("async rst w2", {r2, s2, v2, l2, d2}, 5'b10000);
        q8.delete();
        q2.delete();
        free8 = 0;
        free2 = 0;
        #1 rst = 1'b0;
    endtask

    initial begin
        // start held high during reset must be ignored
        start = 1'b1;
        din   = 8'hFF;
        repeat (3) @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);

        // basic A5 word; din changes right after acceptance; start while busy
        start = 1'b1;
        din   = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        din   = 8'h00;
        repeat (2) @(negedge clk);
        start = 1'b1;
        din   = 8'hFF;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // narrow boundary word 2'b10
        start = 1'b1;
        din   = 8'h02;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // continuous start: one word every WIDTH+2 cycles
        cont       = 1'b1;
        last_done8 = 0;
        start      = 1'b1;
        din        = 8'h3C;
        repeat (42) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        cont = 1'b0;

        // async reset while bit 3 of an A5 word is on sout
        start = 1'b1;
        din   = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("bit3 on sout before rst", {v8, s8}, 2'b10);
        reset_pulse();
        repeat (14) @(negedge clk);

        // randomized traffic with occasional async resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            din   = 8'($urandom);
            if ($urandom_range(0, 59) == 0) reset_pulse();
        end
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("w8 queue drained", q8.size(), 0);
        check("w2 queue drained", q2.size(), 0);

        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
